// File: rtl/mem_stage.sv
// Memory-access stage: loads/stores over a req/gnt/rvalid port, ALU results forwarded to writeback.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses skip memory and pulse o_misaligned.
`ifndef ALEN
`define ALEN 5
`endif

module mem_stage #(
   parameter int XLEN  = 64,
   parameter int RF_AW = `ALEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic             i_is_load,
   input  logic             i_is_store,
   input  logic [1:0]       i_size,
   input  logic             i_unsigned,
   input  logic [XLEN-1:0]  i_addr,
   input  logic [XLEN-1:0]  i_store_data,
   input  logic             i_rf_we,
   input  logic [RF_AW-1:0] i_rd,
   output logic             o_mem_ready,
   output logic [RF_AW-1:0] o_mem_rd,
   output logic             o_dmem_req,
   output logic             o_dmem_we,
   output logic [XLEN-1:0]  o_dmem_addr,
   output logic [XLEN-1:0]  o_dmem_wdata,
   output logic [7:0]       o_dmem_be,
   input  logic             i_dmem_gnt,
   input  logic             i_dmem_rvalid,
   input  logic [XLEN-1:0]  i_dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic             o_misaligned,
`endif
   output logic             o_wb_valid,
   output logic             o_wb_we,
   output logic [RF_AW-1:0] o_wb_rd,
   output logic [XLEN-1:0]  o_wb_data
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

   state_t            state, state_nxt;
   logic              is_store_q, unsigned_q, we_q;
   logic [1:0]        size_q;
   logic [XLEN-1:0]   addr_q, sdata_q;
   logic [RF_AW-1:0]  rd_q;

   // Address bits that must be zero for a size-aligned access.
   function automatic logic [2:0] low_mask(input logic [1:0] size);
      case (size)
         2'b00:   low_mask = 3'b000;
         2'b01:   low_mask = 3'b001;
         2'b10:   low_mask = 3'b011;
         default: low_mask = 3'b111;
      endcase
   endfunction

   function automatic logic [7:0] size_be(input logic [1:0] size);
      case (size)
         2'b00:   size_be = 8'h01;
         2'b01:   size_be = 8'h03;
         2'b10:   size_be = 8'h0F;
         default: size_be = 8'hFF;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata, input logic [2:0] off,
                                                input logic [1:0] size, input logic uns);
      logic [XLEN-1:0] sh;
      sh = rdata >> {off, 3'b000};
      case (size)
         2'b00:   load_ext = uns ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
         2'b01:   load_ext = uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
         2'b10:   load_ext = uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
         default: load_ext = sh;
      endcase
   endfunction

   logic accept, is_mem, misaligned;
   assign accept = i_valid & (state == IDLE);
   assign is_mem = i_is_load | i_is_store;
`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = |(i_addr[2:0] & low_mask(i_size));
`else
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         IDLE:    if (accept && is_mem && !misaligned) state_nxt = REQ;
         REQ:     if (i_dmem_gnt) state_nxt = is_store_q ? IDLE : WAIT_R;
         WAIT_R:  if (i_dmem_rvalid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_mem_ready  = (state == IDLE);
      o_dmem_req   = (state == REQ);
      o_dmem_we    = o_dmem_req & is_store_q;
      o_dmem_addr  = '0;
      o_dmem_be    = '0;
      o_dmem_wdata = '0;
      if (o_dmem_req) begin
         o_dmem_addr  = {addr_q[XLEN-1:3], 3'b000};
         o_dmem_be    = size_be(size_q) << addr_q[2:0];
         o_dmem_wdata = sdata_q << {addr_q[2:0], 3'b000};
      end
      o_mem_rd = (state != IDLE && we_q) ? rd_q : '0;
   end

   // Without the trap, low address bits below the access size are dropped so no access crosses a line.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_store_q <= 1'b0;
         unsigned_q <= 1'b0;
         we_q       <= 1'b0;
         size_q     <= '0;
         addr_q     <= '0;
         sdata_q    <= '0;
         rd_q       <= '0;
         o_wb_valid <= 1'b0;
         o_wb_we    <= 1'b0;
         o_wb_rd    <= '0;
         o_wb_data  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         o_misaligned <= 1'b0;
`endif
      end else begin
         o_wb_valid <= 1'b0;
         o_wb_we    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         o_misaligned <= 1'b0;
`endif
         if (accept) begin
            is_store_q <= i_is_store;
            unsigned_q <= i_unsigned;
            we_q       <= i_rf_we & (i_rd != '0);
            size_q     <= i_size;
            addr_q     <= {i_addr[XLEN-1:3], i_addr[2:0] & ~low_mask(i_size)};
            sdata_q    <= i_store_data;
            rd_q       <= i_rd;
            if (!is_mem) begin
               o_wb_valid <= 1'b1;
               o_wb_we    <= i_rf_we & (i_rd != '0);
               o_wb_rd    <= i_rd;
               o_wb_data  <= i_addr;
            end else if (misaligned) begin
               o_wb_valid <= 1'b1;
               o_wb_rd    <= i_rd;
`ifdef MEM_MISALIGN_TRAP_EN
               o_misaligned <= 1'b1;
`endif
            end
         end
         if (state == REQ && i_dmem_gnt && is_store_q) begin
            o_wb_valid <= 1'b1;
            o_wb_rd    <= rd_q;
         end
         if (state == WAIT_R && i_dmem_rvalid) begin
            o_wb_valid <= 1'b1;
            o_wb_we    <= we_q;
            o_wb_rd    <= rd_q;
            o_wb_data  <= load_ext(i_dmem_rdata, addr_q[2:0], size_q, unsigned_q);
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU forward, loads, delayed-grant store, stall, reset abort, misalignment.
`timescale 1ns/1ps

module tb_mem_stage;
   localparam int XLEN  = 64;
   localparam int RF_AW = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_valid, i_is_load, i_is_store, i_unsigned, i_rf_we;
   logic [1:0]       i_size;
   logic [XLEN-1:0]  i_addr, i_store_data;
   logic [RF_AW-1:0] i_rd;
   logic             o_mem_ready;
   logic [RF_AW-1:0] o_mem_rd;
   logic             o_dmem_req, o_dmem_we;
   logic [XLEN-1:0]  o_dmem_addr, o_dmem_wdata;
   logic [7:0]       o_dmem_be;
   logic             i_dmem_gnt, i_dmem_rvalid;
   logic [XLEN-1:0]  i_dmem_rdata;
   logic             o_wb_valid, o_wb_we;
   logic [RF_AW-1:0] o_wb_rd;
   logic [XLEN-1:0]  o_wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
   logic             o_misaligned;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_stage #(.XLEN(XLEN), .RF_AW(RF_AW)) dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_is_load(i_is_load), .i_is_store(i_is_store),
      .i_size(i_size), .i_unsigned(i_unsigned), .i_addr(i_addr),
      .i_store_data(i_store_data), .i_rf_we(i_rf_we), .i_rd(i_rd),
      .o_mem_ready(o_mem_ready), .o_mem_rd(o_mem_rd),
      .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
      .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
      .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
      .o_misaligned(o_misaligned),
`endif
      .o_wb_valid(o_wb_valid), .o_wb_we(o_wb_we), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] sdata,
                         input logic we, input logic [RF_AW-1:0] rd);
      i_valid = 1'b1; i_is_load = ld; i_is_store = st; i_size = sz; i_unsigned = uns;
      i_addr = addr; i_store_data = sdata; i_rf_we = we; i_rd = rd;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " ready"},   o_mem_ready, 1'b1);
      check({tag, " mem_rd"},  o_mem_rd, 0);
      check({tag, " req"},     o_dmem_req, 1'b0);
      check({tag, " dwe"},     o_dmem_we, 1'b0);
      check({tag, " daddr"},   o_dmem_addr, 0);
      check({tag, " be"},      o_dmem_be, 0);
      check({tag, " wdata"},   o_dmem_wdata, 0);
      check({tag, " wb_valid"}, o_wb_valid, 1'b0);
      check({tag, " wb_we"},   o_wb_we, 1'b0);
      check({tag, " wb_rd"},   o_wb_rd, 0);
      check({tag, " wb_data"}, o_wb_data, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] lb_exp [2];
      lb_exp[0] = 64'hFFFF_FFFF_FFFF_FF80;
      lb_exp[1] = 64'h0000_0000_0000_0080;

      rst = 1'b1; i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0; i_size = 2'b00;
      i_unsigned = 1'b0; i_addr = '0; i_store_data = '0; i_rf_we = 1'b0; i_rd = '0;
      i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      // ALU forward
      @(negedge clk);
      set_op(0, 0, 2'b11, 0, 64'h1234, 64'h0, 1, 5'd5);
      check("add ready", o_mem_ready, 1'b1);
      @(negedge clk);
      i_valid = 1'b0;
      check("add wb_valid", o_wb_valid, 1'b1);
      check("add wb_data", o_wb_data, 64'h1234);
      check("add wb_rd", o_wb_rd, 5);
      check("add wb_we", o_wb_we, 1'b1);
      check("add req", o_dmem_req, 1'b0);
      @(negedge clk);
      check("add pulse end", o_wb_valid, 1'b0);

      // LB then LBU at 0x1003, gnt immediate, rvalid two cycles after gnt
      for (int u = 0; u < 2; u++) begin
         set_op(1, 0, 2'b00, u[0], 64'h1003, 64'h0, 1, 5'd3);
         @(negedge clk);
         i_valid = 1'b0;
         check("lb req", o_dmem_req, 1'b1);
         check("lb daddr", o_dmem_addr, 64'h1000);
         check("lb be", o_dmem_be, 8'h08);
         check("lb dwe", o_dmem_we, 1'b0);
         check("lb ready", o_mem_ready, 1'b0);
         check("lb mem_rd", o_mem_rd, 3);
         i_dmem_gnt = 1'b1;
         @(negedge clk);
         i_dmem_gnt = 1'b0;
         check("lb req drop", o_dmem_req, 1'b0);
         check("lb wait mem_rd", o_mem_rd, 3);
         @(negedge clk);
         check("lb no early wb", o_wb_valid, 1'b0);
         i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'h0000_0000_8000_0000;
         @(negedge clk);
         i_dmem_rvalid = 1'b0;
         check("lb wb_valid", o_wb_valid, 1'b1);
         check("lb wb_data", o_wb_data, lb_exp[u]);
         check("lb wb_we", o_wb_we, 1'b1);
         check("lb wb_rd", o_wb_rd, 3);
         check("lb ready after", o_mem_ready, 1'b1);
         check("lb mem_rd after", o_mem_rd, 0);
         @(negedge clk);
         check("lb pulse end", o_wb_valid, 1'b0);
      end

      // SH 0xBEEF at 0x2006, gnt after three wait cycles, stale rvalid during REQ
      set_op(0, 1, 2'b01, 0, 64'h2006, 64'hBEEF, 0, 5'd9);
      @(negedge clk);
      i_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("sh req", o_dmem_req, 1'b1);
         check("sh dwe", o_dmem_we, 1'b1);
         check("sh daddr", o_dmem_addr, 64'h2000);
         check("sh be", o_dmem_be, 8'hC0);
         check("sh wdata", o_dmem_wdata, 64'hBEEF_0000_0000_0000);
         check("sh ready", o_mem_ready, 1'b0);
         check("sh mem_rd", o_mem_rd, 0);
         check("sh no wb", o_wb_valid, 1'b0);
         i_dmem_rvalid = (k == 1);
         i_dmem_gnt    = (k == 3);
         @(negedge clk);
      end
      i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
      check("sh wb_valid", o_wb_valid, 1'b1);
      check("sh wb_we", o_wb_we, 1'b0);
      check("sh ready after", o_mem_ready, 1'b1);
      check("sh req after", o_dmem_req, 1'b0);

      // LD rd=7 with a second instruction held on i_valid while busy
      set_op(1, 0, 2'b11, 0, 64'h4008, 64'h0, 1, 5'd7);
      @(negedge clk);
      set_op(0, 0, 2'b11, 0, 64'h55, 64'h0, 1, 5'd2);
      check("ld ready", o_mem_ready, 1'b0);
      check("ld mem_rd req", o_mem_rd, 7);
      check("ld daddr", o_dmem_addr, 64'h4008);
      check("ld be", o_dmem_be, 8'hFF);
      i_dmem_gnt = 1'b1;
      @(negedge clk);
      i_dmem_gnt = 1'b0;
      check("ld mem_rd wait", o_mem_rd, 7);
      check("ld no wb", o_wb_valid, 1'b0);
      i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      i_dmem_rvalid = 1'b0;
      check("ld wb_valid", o_wb_valid, 1'b1);
      check("ld wb_data", o_wb_data, 64'h0123_4567_89AB_CDEF);
      check("ld wb_rd", o_wb_rd, 7);
      check("ld mem_rd clr", o_mem_rd, 0);
      @(negedge clk);
      i_valid = 1'b0;
      check("held op wb_valid", o_wb_valid, 1'b1);
      check("held op wb_rd", o_wb_rd, 2);
      check("held op wb_data", o_wb_data, 64'h55);

      // LW to x0 at 0x3004, sign extension
      set_op(1, 0, 2'b10, 0, 64'h3004, 64'h0, 1, 5'd0);
      @(negedge clk);
      i_valid = 1'b0;
      check("lw0 be", o_dmem_be, 8'hF0);
      check("lw0 mem_rd", o_mem_rd, 0);
      i_dmem_gnt = 1'b1;
      @(negedge clk);
      i_dmem_gnt = 1'b0;
      i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'h8000_0000_0000_0000;
      @(negedge clk);
      i_dmem_rvalid = 1'b0;
      check("lw0 wb_valid", o_wb_valid, 1'b1);
      check("lw0 wb_we", o_wb_we, 1'b0);
      check("lw0 wb_data", o_wb_data, 64'hFFFF_FFFF_8000_0000);

      // Reset during WAIT_R; late response must be discarded
      set_op(1, 0, 2'b01, 1, 64'h10, 64'h0, 1, 5'd4);
      @(negedge clk);
      i_valid = 1'b0;
      i_dmem_gnt = 1'b1;
      @(negedge clk);
      i_dmem_gnt = 1'b0;
      check("rst mid mem_rd", o_mem_rd, 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'hFFFF;
      check_reset_state("rst mid");
      @(negedge clk);
      i_dmem_rvalid = 1'b0;
      check_reset_state("rst stale");
      @(negedge clk);
      check("rst no wb later", o_wb_valid, 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
      set_op(1, 0, 2'b10, 0, 64'h3002, 64'h0, 1, 5'd6);
      @(negedge clk);
      i_valid = 1'b0;
      check("mis req", o_dmem_req, 1'b0);
      check("mis pulse", o_misaligned, 1'b1);
      check("mis wb_valid", o_wb_valid, 1'b1);
      check("mis wb_we", o_wb_we, 1'b0);
      check("mis ready", o_mem_ready, 1'b1);
      @(negedge clk);
      check("mis pulse end", o_misaligned, 1'b0);
      check("mis wb end", o_wb_valid, 1'b0);
      check("mis req after", o_dmem_req, 1'b0);
`else
      set_op(1, 0, 2'b10, 0, 64'h3002, 64'h0, 1, 5'd6);
      @(negedge clk);
      i_valid = 1'b0;
      check("mis daddr", o_dmem_addr, 64'h3000);
      check("mis be", o_dmem_be, 8'h0F);
      i_dmem_gnt = 1'b1;
      @(negedge clk);
      i_dmem_gnt = 1'b0;
      i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'h1122_3344_5566_7788;
      @(negedge clk);
      i_dmem_rvalid = 1'b0;
      check("mis wb_valid", o_wb_valid, 1'b1);
      check("mis wb_data", o_wb_data, 64'h5566_7788);
      check("mis wb_we", o_wb_we, 1'b1);
`endif

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order pipeline, directly downstream of the execute stage and upstream of writeback.
- Accepts one executed instruction per handshake and performs loads/stores over a request/grant/rvalid data-memory port.
- Aligns and extends load data, and forwards ALU results unchanged.
- Reports back-pressure (`o_mem_ready`) and its destination register (`o_mem_rd`) to the execute stage's stall controller.

## Interface
- `XLEN`, 64, data/address width.
- `RF_AW`, `` `ALEN ``, register-file address width.
- `clk` in 1 — sole clock, rising edge.
- `rst` in 1 — reset; synchronous, active-high.
- `i_valid` in 1 — instruction from EX is valid.
- `i_is_load`, `i_is_store` in 1 each — access type; never both set.
- `i_size` in 2 — 00 byte, 01 half, 10 word, 11 double.
- `i_unsigned` in 1 — zero-extend the load (LBU/LHU/LWU).
- `i_addr` in XLEN — effective address; ALU result for non-memory ops.
- `i_store_data` in XLEN — rs2 value, right-aligned.
- `i_rf_we` in 1, `i_rd` in RF_AW — writeback request and destination.
- `o_mem_ready` out 1 — stage can accept; handshake = `i_valid & o_mem_ready`.
- `o_mem_rd` out RF_AW — rd of the instruction held in MEM; 0 if none or no write.
- `o_dmem_req`, `o_dmem_we` out 1; `o_dmem_addr` out XLEN (8-byte aligned); `o_dmem_wdata` out XLEN; `o_dmem_be` out 8.
- `i_dmem_gnt`, `i_dmem_rvalid` in 1; `i_dmem_rdata` in XLEN.
- `o_wb_valid`, `o_wb_we` out 1; `o_wb_rd` out RF_AW; `o_wb_data` out XLEN — registered to WB.
- `o_misaligned` out 1 — one-cycle pulse, only when the macro is defined.

## Operation
- FSM states: IDLE, REQ, WAIT_R.
- IDLE:
  - Handshake with a non-memory op: register `i_addr` as result; `o_wb_valid` is high the next cycle.
  - Handshake with a load/store: latch all fields and go to REQ.
- REQ:
  - Drive `o_dmem_req=1`, `o_dmem_we=is_store`, address `{addr[XLEN-1:3],3'b0}`.
  - `be` = size mask (01h/03h/0Fh/FFh) << `addr[2:0]`; wdata = `store_data << (8*addr[2:0])`.
  - Hold all dmem outputs stable until `i_dmem_gnt`.
  - On gnt: a store goes to IDLE and emits `o_wb_valid` with `o_wb_we=0` next cycle; a load goes to WAIT_R.
- WAIT_R:
  - On `i_dmem_rvalid`: shift rdata right by `8*addr[2:0]`, truncate to size, sign/zero-extend to XLEN.
  - Register into `o_wb_data` with `o_wb_we=i_rf_we` and go to IDLE.
- `o_mem_ready` = (state==IDLE). No new acceptance in the same cycle as a gnt/rvalid completion.
- `o_mem_rd` reflects the latched rd from acceptance until the cycle `o_wb_valid` rises. It reads 0 for x0.
- `rd==0` loads still access memory; `o_wb_we` is forced to 0.
- `i_dmem_rvalid` in IDLE or REQ is ignored (stale response).
- Accesses never cross an 8-byte line; an access that would cross one is misaligned (see Configuration).

## Timing
- Reset: state IDLE; `o_mem_ready=1`; `o_mem_rd=0`; all `o_dmem_*`=0; `o_wb_valid=0`, `o_wb_we=0`, `o_wb_rd=0`, `o_wb_data=0`; `o_misaligned=0`.
- Non-memory op: handshake at edge N, then `o_wb_valid` for one cycle after N.
- Store: req from cycle N+1; gnt in cycle N+1+k; `o_wb_valid` after edge N+2+k.
- Load: same request phase; rvalid at cycle ≥ gnt+1; `o_wb_valid` one cycle after rvalid. Minimum latency 3 cycles.
- `o_wb_valid` is a one-cycle pulse per instruction. WB has no back-pressure.
- `rst` asserted mid-transaction: next edge forces IDLE and drops `o_dmem_req`. An outstanding response is discarded.

## Configuration
- `MEM_MISALIGN_TRAP_EN`:
  - Defined: a load/store with `addr` not size-aligned skips dmem entirely.
  - In that case `o_misaligned` pulses, and `o_wb_valid` pulses one cycle after acceptance with `o_wb_we=0`.
  - Undefined: the `o_misaligned` port is absent. `addr` low bits below the access size are cleared before the access; no trap.

## Test plan
- ADD result 0x1234, rd=5, non-memory → one cycle later `o_wb_valid=1`, `o_wb_data=0x1234`, `o_wb_rd=5`, `o_wb_we=1`.
- LB at addr 0x1003, rdata 0x00000000_80000000, gnt immediate, rvalid +2 → `be=08h`, `o_wb_data=0xFFFF_FFFF_FFFF_FF80`. The same access as LBU gives 0x80.
- SH data 0xBEEF at 0x2006 with gnt delayed 3 cycles → req/addr 0x2000/`be=C0h`/wdata 0xBEEF_0000_0000_0000 held stable. `o_mem_ready=0` and `o_mem_rd=0` (no write) throughout.
- LD rd=7 outstanding → `o_mem_rd=7` until the wb pulse. A new `i_valid` is not accepted until IDLE.
- `rst` pulse during WAIT_R, then rvalid arrives → no `o_wb_valid`, and all outputs are at reset values.
- With `MEM_MISALIGN_TRAP_EN`, LW at 0x3002 → `o_dmem_req` stays 0, `o_misaligned` pulses, `o_wb_we=0`.
